// File: rtl/cnn_load_sequencer_if.sv
// Stream/bus bundle for cnn_load_sequencer.
// Groups the data and filter stream handshakes, the captured dimensions,
// the accelerator write port, the start/result handshake and status flags.
//   master : stream sources and accelerator side (drive data/filt/resValidIn)
//   slave  : the sequencer (drives readies, dimensions, write port, status)
interface cnn_load_sequencer_if #(
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_SIZE       = 4096
);
   localparam int BUS_WE_WIDTH = BUS_DATA_WIDTH / 8;
   localparam int DIM_WIDTH    = $clog2(MAX_SIZE) + 1;

   logic [DATA_WIDTH-1:0]     dataIn;
   logic                      dataValidIn;
   logic                      dataLastIn;
   logic                      dataReadyOut;
   logic [DATA_WIDTH-1:0]     filtIn;
   logic                      filtValidIn;
   logic                      filtLastIn;
   logic                      filtReadyOut;
   logic [DIM_WIDTH-1:0]      dataRowsOut;
   logic [DIM_WIDTH-1:0]      dataColsOut;
   logic [DIM_WIDTH-1:0]      filtRowsOut;
   logic [DIM_WIDTH-1:0]      filtColsOut;
   logic [BUS_ADDR_WIDTH-1:0] addrOut;
   logic [BUS_WE_WIDTH-1:0]   wrEnOut;
   logic [BUS_DATA_WIDTH-1:0] wrDataOut;
   logic                      startOut;
   logic                      resValidIn;
   logic                      busyOut;
   logic                      doneOut;
   logic                      errorOut;

   modport master (
      output dataIn, dataValidIn, dataLastIn, input dataReadyOut,
      output filtIn, filtValidIn, filtLastIn, input filtReadyOut,
      input dataRowsOut, dataColsOut, filtRowsOut, filtColsOut,
      input addrOut, wrEnOut, wrDataOut, startOut,
      output resValidIn,
      input busyOut, doneOut, errorOut
   );

   modport slave (
      input dataIn, dataValidIn, dataLastIn, output dataReadyOut,
      input filtIn, filtValidIn, filtLastIn, output filtReadyOut,
      output dataRowsOut, dataColsOut, filtRowsOut, filtColsOut,
      output addrOut, wrEnOut, wrDataOut, startOut,
      input resValidIn,
      output busyOut, doneOut, errorOut
   );
endinterface

// File: rtl/cnn_load_sequencer.sv
// Front-end load controller for the CNN accelerator.
// Receives a data-matrix stream and then a filter-matrix stream (each: cols
// header, rows header, row-major payload), packs 32-bit payload words into
// bus-width write beats, pulses start once both matrices are loaded, then
// counts result handshakes until the expected number of outputs is seen.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus (slave): data/filt streams (valid/ready/last), captured dimensions,
//                addrOut/wrEnOut/wrDataOut write port, startOut, resValidIn,
//                busyOut/doneOut/errorOut status. All outputs registered.
module cnn_load_sequencer #(
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_SIZE       = 4096
) (
   input logic                 clk,
   input logic                 rst,
   cnn_load_sequencer_if.slave bus
);
   localparam int BUS_WE_WIDTH = BUS_DATA_WIDTH / 8;
   localparam int NUM_WORDS    = BUS_DATA_WIDTH / DATA_WIDTH;
   localparam int WORD_BYTES   = DATA_WIDTH / 8;
   localparam int DIM_WIDTH    = $clog2(MAX_SIZE) + 1;
   localparam int CNT_WIDTH    = 2 * DIM_WIDTH;
   localparam int LANE_WIDTH   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [BUS_ADDR_WIDTH-1:0] FILT_ADDR =
      BUS_ADDR_WIDTH'(1 << ($clog2(MAX_SIZE) + $clog2(WORD_BYTES)));
   localparam logic [BUS_ADDR_WIDTH-1:0] BEAT_STRIDE = BUS_ADDR_WIDTH'(BUS_WE_WIDTH);

   typedef enum logic [3:0] {
      IDLE  = 4'd0, DCOLS = 4'd1, DROWS = 4'd2, DLOAD = 4'd3, FCOLS = 4'd4,
      FROWS = 4'd5, FLOAD = 4'd6, START = 4'd7, RUN   = 4'd8, ERR   = 4'd9
   } state_t;

   // Byte enables covering every lane from 0 up to and including top_lane.
   function automatic logic [BUS_WE_WIDTH-1:0] lane_mask(input logic [LANE_WIDTH-1:0] top_lane);
      logic [BUS_WE_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (i <= int'(top_lane)) m[i*WORD_BYTES +: WORD_BYTES] = '1;
         else                     m[i*WORD_BYTES +: WORD_BYTES] = '0;
      end
      return m;
   endfunction

   state_t                               state;
   logic [DIM_WIDTH-1:0]                 total, beat_cnt, beat_num, hdr_dim, hdr_cols;
   logic [LANE_WIDTH-1:0]                lane;
   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] pack, pack_next;
   logic [BUS_ADDR_WIDTH-1:0]            offset, base;
   logic [CNT_WIDTH-1:0]                 res_cnt, res_next, res_expected, exp_count, hdr_prod;
   logic [DATA_WIDTH-1:0]                in_word;
   logic                                 is_filt, accept, in_last, hdr_bad, at_total, lane_last;

   // Select the active stream and precompute header/length/packing decisions.
   always_comb begin
      is_filt = (state == FCOLS) || (state == FROWS) || (state == FLOAD);
      if (is_filt) begin
         in_word  = bus.filtIn;
         in_last  = bus.filtLastIn;
         accept   = bus.filtValidIn && bus.filtReadyOut;
         hdr_cols = bus.filtColsOut;
         base     = FILT_ADDR;
      end else begin
         in_word  = bus.dataIn;
         in_last  = bus.dataLastIn;
         accept   = bus.dataValidIn && bus.dataReadyOut;
         hdr_cols = bus.dataColsOut;
         base     = '0;
      end
      hdr_dim  = in_word[DIM_WIDTH-1:0];
      hdr_prod = CNT_WIDTH'(hdr_dim) * CNT_WIDTH'(hdr_cols);
      hdr_bad  = (hdr_dim == '0) || (hdr_cols == '0) || in_last ||
                 (hdr_prod > CNT_WIDTH'(MAX_SIZE));
      // The filter must fit inside the data matrix in both dimensions.
      if (is_filt) begin
         hdr_bad = hdr_bad || (hdr_dim > bus.dataRowsOut) || (bus.filtColsOut > bus.dataColsOut);
      end else begin
         hdr_bad = hdr_bad;
      end
      beat_num  = beat_cnt + DIM_WIDTH'(1);
      at_total  = (beat_num == total);
      lane_last = (lane == LANE_WIDTH'(NUM_WORDS - 1));
      pack_next = pack;
      pack_next[lane] = in_word;
      res_next  = res_cnt + CNT_WIDTH'(1);
      exp_count = CNT_WIDTH'(bus.dataRowsOut - bus.filtRowsOut + DIM_WIDTH'(1)) *
                  CNT_WIDTH'(bus.dataColsOut - bus.filtColsOut + DIM_WIDTH'(1));
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         total            <= '0;
         beat_cnt         <= '0;
         lane             <= '0;
         pack             <= '0;
         offset           <= '0;
         res_cnt          <= '0;
         res_expected     <= '0;
         bus.dataReadyOut <= 1'b0;
         bus.filtReadyOut <= 1'b0;
         bus.dataRowsOut  <= '0;
         bus.dataColsOut  <= '0;
         bus.filtRowsOut  <= '0;
         bus.filtColsOut  <= '0;
         bus.addrOut      <= '0;
         bus.wrEnOut      <= '0;
         bus.wrDataOut    <= '0;
         bus.startOut     <= 1'b0;
         bus.busyOut      <= 1'b0;
         bus.doneOut      <= 1'b0;
         bus.errorOut     <= 1'b0;
      end else begin
         // Writes, start and done are single-cycle unless re-issued below.
         bus.addrOut   <= '0;
         bus.wrEnOut   <= '0;
         bus.wrDataOut <= '0;
         bus.startOut  <= 1'b0;
         bus.doneOut   <= 1'b0;
         case (state)
            IDLE: begin
               bus.dataReadyOut <= 1'b0;
               bus.filtReadyOut <= 1'b0;
               if (bus.dataValidIn) begin
                  bus.dataReadyOut <= 1'b1;
                  bus.busyOut      <= 1'b1;
                  beat_cnt         <= '0;
                  lane             <= '0;
                  offset           <= '0;
                  state            <= DCOLS;
               end
            end
            DCOLS, FCOLS: begin
               if (accept) begin
                  if (in_last) begin
                     bus.dataReadyOut <= 1'b0;
                     bus.filtReadyOut <= 1'b0;
                     bus.errorOut     <= 1'b1;
                     state            <= ERR;
                  end else if (is_filt) begin
                     bus.filtColsOut <= hdr_dim;
                     state           <= FROWS;
                  end else begin
                     bus.dataColsOut <= hdr_dim;
                     state           <= DROWS;
                  end
               end
            end
            DROWS, FROWS: begin
               if (accept) begin
                  if (is_filt) bus.filtRowsOut <= hdr_dim;
                  else         bus.dataRowsOut <= hdr_dim;
                  if (hdr_bad) begin
                     bus.dataReadyOut <= 1'b0;
                     bus.filtReadyOut <= 1'b0;
                     bus.errorOut     <= 1'b1;
                     state            <= ERR;
                  end else begin
                     total    <= hdr_prod[DIM_WIDTH-1:0];
                     beat_cnt <= '0;
                     lane     <= '0;
                     offset   <= '0;
                     state    <= is_filt ? FLOAD : DLOAD;
                  end
               end
            end
            DLOAD, FLOAD: begin
               if (accept) begin
                  // last must coincide exactly with beat number rows*cols.
                  if (in_last != at_total) begin
                     bus.dataReadyOut <= 1'b0;
                     bus.filtReadyOut <= 1'b0;
                     bus.errorOut     <= 1'b1;
                     state            <= ERR;
                  end else begin
                     pack     <= pack_next;
                     beat_cnt <= beat_num;
                     lane     <= lane_last ? '0 : lane + LANE_WIDTH'(1);
                     if (lane_last || in_last) begin
                        bus.addrOut   <= base + offset;
                        bus.wrEnOut   <= lane_mask(lane);
                        bus.wrDataOut <= pack_next;
                        offset        <= offset + BEAT_STRIDE;
                     end
                     if (in_last) begin
                        beat_cnt <= '0;
                        lane     <= '0;
                        offset   <= '0;
                        if (is_filt) begin
                           bus.filtReadyOut <= 1'b0;
                           state            <= START;
                        end else begin
                           bus.dataReadyOut <= 1'b0;
                           bus.filtReadyOut <= 1'b1;
                           state            <= FCOLS;
                        end
                     end
                  end
               end
            end
            START: begin
               bus.startOut <= 1'b1;
               res_expected <= exp_count;
               res_cnt      <= '0;
               state        <= RUN;
            end
            RUN: begin
               if (bus.resValidIn) begin
                  if (res_next == res_expected) begin
                     bus.doneOut <= 1'b1;
                     bus.busyOut <= 1'b0;
                     res_cnt     <= '0;
                     state       <= IDLE;
                  end else begin
                     res_cnt <= res_next;
                  end
               end
            end
            ERR: begin
               bus.dataReadyOut <= 1'b0;
               bus.filtReadyOut <= 1'b0;
               bus.errorOut     <= 1'b1;
            end
            default: begin
               bus.dataReadyOut <= 1'b0;
               bus.filtReadyOut <= 1'b0;
               bus.errorOut     <= 1'b1;
               state            <= ERR;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Directed bench for cnn_load_sequencer: full frames with and without
// stalls, partial last beat, filter-too-large error, early-last error and
// reset in the middle of a data load.
module tb_cnn_load_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cnn_load_sequencer_if bus();
   cnn_load_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] wr_addr[$];
   logic [7:0]  wr_en[$];
   logic [63:0] wr_data[$];
   int start_cnt = 0;
   int overlap_cnt = 0;

   // Record every write beat and start pulse on the falling edge.
   always @(negedge clk) begin
      if (bus.wrEnOut != 8'h00) begin
         wr_addr.push_back(bus.addrOut);
         wr_en.push_back(bus.wrEnOut);
         wr_data.push_back(bus.wrDataOut);
      end
      if (bus.startOut) begin
         start_cnt++;
         if (bus.wrEnOut != 8'h00) overlap_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_en.delete();
      wr_data.delete();
   endtask

   task automatic drive(input bit filt, input bit valid, input logic [31:0] w, input bit last);
      if (filt) begin
         bus.filtValidIn = valid; bus.filtIn = w; bus.filtLastIn = last;
      end else begin
         bus.dataValidIn = valid; bus.dataIn = w; bus.dataLastIn = last;
      end
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      bus.resValidIn = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_log();
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic push(input bit filt, input logic [31:0] w, input bit last, input bit stall);
      int guard;
      guard = 0;
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      drive(filt, 1'b1, w, last);
      while (!(filt ? bus.filtReadyOut : bus.dataReadyOut) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard < 100) @(negedge clk);
      check_eq("ready_wait", 64'(guard < 100), 64'd1);
      drive(filt, 1'b0, 32'd0, 1'b0);
   endtask

   // Expected writes for words 1..n packed two per beat starting at base.
   task automatic check_writes(input string tag, input int n, input int first, input int base);
      for (int k = 0; k < (n + 1) / 2; k++) begin
         logic [31:0] lo, hi;
         logic [63:0] msk;
         bit full;
         lo = 32'(2 * k + 1);
         hi = 32'(2 * k + 2);
         full = (2 * k + 2) <= n;
         msk = full ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
         check_eq({tag, "_addr"}, 64'(wr_addr[first + k]), 64'(base + 8 * k));
         check_eq({tag, "_en"}, 64'(wr_en[first + k]), full ? 64'hFF : 64'h0F);
         check_eq({tag, "_data"}, wr_data[first + k] & msk, {hi, lo} & msk);
      end
   endtask

   task automatic run_frame(input int dr, input int dc, input int fr, input int fc, input bit stall);
      int nd, nf, nres, s0, guard;
      nd = dr * dc;
      nf = fr * fc;
      nres = (dr - fr + 1) * (dc - fc + 1);
      clear_log();
      s0 = start_cnt;
      push(1'b0, 32'(dc), 1'b0, stall);
      push(1'b0, 32'(dr), 1'b0, stall);
      for (int i = 1; i <= nd; i++) push(1'b0, 32'(i), i == nd, stall);
      push(1'b1, 32'(fc), 1'b0, stall);
      push(1'b1, 32'(fr), 1'b0, stall);
      for (int i = 1; i <= nf; i++) push(1'b1, 32'(i), i == nf, stall);
      guard = 0;
      while (start_cnt == s0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      check_eq("start_once", 64'(start_cnt - s0), 64'd1);
      check_eq("start_no_write", 64'(overlap_cnt), 64'd0);
      check_eq("wr_count", 64'(wr_addr.size()), 64'((nd + 1) / 2 + (nf + 1) / 2));
      if (wr_addr.size() == (nd + 1) / 2 + (nf + 1) / 2) begin
         check_writes("dwr", nd, 0, 0);
         check_writes("fwr", nf, (nd + 1) / 2, 16384);
      end
      for (int k = 1; k <= nres; k++) begin
         if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
         check_eq("done_early", 64'(bus.doneOut), 64'd0);
         bus.resValidIn = 1'b1;
         @(negedge clk);
         bus.resValidIn = 1'b0;
      end
      check_eq("done_pulse", 64'(bus.doneOut), 64'd1);
      check_eq("busy_fall", 64'(bus.busyOut), 64'd0);
      @(negedge clk);
      check_eq("done_one_cycle", 64'(bus.doneOut), 64'd0);
      check_eq("dims_hold", {bus.dataRowsOut, bus.dataColsOut, bus.filtRowsOut, bus.filtColsOut},
               {13'(dr), 13'(dc), 13'(fr), 13'(fc)});
   endtask

   initial begin
      int s0;
      // Reset state
      do_reset();
      check_eq("rst_ready", {bus.dataReadyOut, bus.filtReadyOut}, 64'd0);
      check_eq("rst_status", {bus.busyOut, bus.doneOut, bus.errorOut, bus.startOut}, 64'd0);
      check_eq("rst_wr", {bus.wrEnOut, bus.addrOut}, 64'd0);
      check_eq("rst_wrdata", bus.wrDataOut, 64'd0);
      check_eq("rst_dims", {bus.dataRowsOut, bus.dataColsOut, bus.filtRowsOut, bus.filtColsOut}, 64'd0);

      // 4x4 data, 3x3 filter, continuous and then stalled
      run_frame(4, 4, 3, 3, 1'b0);
      run_frame(4, 4, 3, 3, 1'b1);

      // 3x3 data: fifth write is a half beat holding word 9
      run_frame(3, 3, 2, 2, 1'b0);
      if (wr_addr.size() >= 5) begin
         check_eq("p3_addr", 64'(wr_addr[4]), 64'd32);
         check_eq("p3_en", 64'(wr_en[4]), 64'h0F);
         check_eq("p3_lo", 64'(wr_data[4][31:0]), 64'd9);
      end

      // Filter larger than data -> sticky error
      do_reset();
      s0 = start_cnt;
      push(1'b0, 32'd4, 1'b0, 1'b0);
      push(1'b0, 32'd4, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) push(1'b0, 32'(i), i == 16, 1'b0);
      push(1'b1, 32'd5, 1'b0, 1'b0);
      check_eq("f5_no_err_cols", 64'(bus.errorOut), 64'd0);
      push(1'b1, 32'd5, 1'b0, 1'b0);
      check_eq("f5_err", 64'(bus.errorOut), 64'd1);
      check_eq("f5_ready", {bus.dataReadyOut, bus.filtReadyOut}, 64'd0);
      repeat (20) @(negedge clk);
      check_eq("f5_err_sticky", 64'(bus.errorOut), 64'd1);
      check_eq("f5_busy", 64'(bus.busyOut), 64'd1);
      check_eq("f5_no_start", 64'(start_cnt - s0), 64'd0);
      check_eq("f5_wr_count", 64'(wr_addr.size()), 64'd8);

      // Early last on beat 15 of a 4x4 frame
      do_reset();
      check_eq("f5_err_cleared", 64'(bus.errorOut), 64'd0);
      push(1'b0, 32'd4, 1'b0, 1'b0);
      push(1'b0, 32'd4, 1'b0, 1'b0);
      for (int i = 1; i <= 14; i++) push(1'b0, 32'(i), 1'b0, 1'b0);
      check_eq("el_no_err", 64'(bus.errorOut), 64'd0);
      push(1'b0, 32'd15, 1'b1, 1'b0);
      check_eq("el_err", 64'(bus.errorOut), 64'd1);
      repeat (10) @(negedge clk);
      check_eq("el_wr_count", 64'(wr_addr.size()), 64'd7);
      check_eq("el_ready", {bus.dataReadyOut, bus.filtReadyOut}, 64'd0);

      // Reset during the data load, then a fresh 2x2 / 1x1 frame
      do_reset();
      push(1'b0, 32'd4, 1'b0, 1'b0);
      push(1'b0, 32'd4, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) push(1'b0, 32'(100 + i), 1'b0, 1'b0);
      check_eq("mid_wr_count", 64'(wr_addr.size()), 64'd2);
      do_reset();
      check_eq("mid_rst_status", {bus.busyOut, bus.errorOut, bus.dataReadyOut}, 64'd0);
      check_eq("mid_rst_dims", {bus.dataRowsOut, bus.dataColsOut}, 64'd0);
      run_frame(2, 2, 1, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cnn_load_sequencer.md
# cnn_load_sequencer

Front-end controller for `cnn_hw_accelerator`. It accepts a data-matrix stream and a filter-matrix stream, each a two-word header followed by a row-major payload. It packs the 32-bit payload words into bus-width write beats for the accelerator's internal memory, pulses `start` once both matrices are loaded, and counts result beats until the convolution completes. It sits between the RISC-V-side stream sources and the accelerator's `addrIn`/`wrEnIn`/`wrDataIn`/`startIn` bus port.

## Interface

- `BUS_ADDR_WIDTH`, 32, accelerator address width
- `BUS_DATA_WIDTH`, 64, write-beat width; `BUS_WE_WIDTH = BUS_DATA_WIDTH/8`
- `DATA_WIDTH`, 32, stream word width; `NUM_WORDS = BUS_DATA_WIDTH/DATA_WIDTH`
- `MAX_SIZE`, 4096, max rows*cols; `DIM_WIDTH = $clog2(MAX_SIZE)+1`; `FILT_ADDR = 1 << ($clog2(MAX_SIZE)+$clog2(DATA_WIDTH/8))` (16384 at defaults)

Ports:

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `dataIn` in DATA_WIDTH; `dataValidIn` in 1; `dataLastIn` in 1; `dataReadyOut` out 1: data stream
- `filtIn` in DATA_WIDTH; `filtValidIn` in 1; `filtLastIn` in 1; `filtReadyOut` out 1: filter stream
- `dataRowsOut`, `dataColsOut`, `filtRowsOut`, `filtColsOut` out DIM_WIDTH each: captured dimensions, to accelerator
- `addrOut` out BUS_ADDR_WIDTH; `wrEnOut` out BUS_WE_WIDTH; `wrDataOut` out BUS_DATA_WIDTH: write port
- `startOut` out 1: one-cycle start pulse
- `resValidIn` in 1: accelerator result handshake (`validOut && readyIn`)
- `busyOut` out 1: high in every state except IDLE
- `doneOut` out 1: one-cycle completion pulse
- `errorOut` out 1: sticky format error

## Operation

- Beat accepted when `valid && ready`. Only one stream's ready is high at a time.
- States: IDLE, DCOLS, DROWS, DLOAD, FCOLS, FROWS, FLOAD, START, RUN, ERR.
- IDLE: both readies low. When `dataValidIn` is seen, assert `dataReadyOut` and go to DCOLS.
- DCOLS / DROWS: capture `dataIn[DIM_WIDTH-1:0]` into the cols register, then the rows register. Same rule for FCOLS / FROWS on the filter stream.
- Header check, performed on the rows beat:
  - dimension == 0 → ERR
  - rows*cols > MAX_SIZE → ERR
  - `last` asserted on a header beat → ERR
  - filter: filtRows > dataRows or filtCols > dataCols → ERR
- DLOAD / FLOAD packing:
  - Payload word n goes to lane `n % NUM_WORDS` of the pack register.
  - A write is issued when lane == NUM_WORDS-1 or on the last beat.
  - `wrEnOut` asserts all bytes of lanes 0..current lane; other lanes are 0.
  - Address of the first write is the base (0 for data, FILT_ADDR for filter). Each subsequent write adds BUS_WE_WIDTH.
  - Unused lanes of a partial beat carry stale data; their byte enables are 0.
- Length check: the last beat must be beat number rows*cols (counted from 1).
  - `last` early → ERR.
  - Count reaches rows*cols without `last` → ERR.
- After data last: drop `dataReadyOut`, raise `filtReadyOut` the next cycle, go to FCOLS.
- After filter last: drop `filtReadyOut`, go to START.
- START: `startOut` = 1 for one cycle. Load the expected result count `(dR-fR+1)*(dC-fC+1)` (2*DIM_WIDTH bits), then go to RUN.
- RUN: count `resValidIn` cycles. When the count reaches the expected value, pulse `doneOut` and return to IDLE.
  - `resValidIn` outside RUN is ignored.
- ERR: both readies low, `errorOut` = 1, no writes. The block stays in ERR until `rst`.

## Timing

- Reset values: all outputs 0. Dimension registers 0, state IDLE, counters 0.
- All outputs are registered.
- The write triggered by an accepted beat appears on `addrOut`/`wrEnOut`/`wrDataOut` the cycle after acceptance, for exactly one cycle.
- `startOut` rises the cycle after the final filter write beat. It never coincides with a write.
- `doneOut` is asserted the cycle after the final counted `resValidIn`.
- Dimension outputs change only on header capture. They hold stable through RUN and after done.
- A stall (`valid` low) inserts no writes and does not corrupt lane position.
- Reset mid-operation aborts immediately. The next frame is loaded from IDLE with base addresses.

## Test plan

- Data 4x4 words 1..16, filter 3x3 words 1..9, continuous valid → required response:
  - data: 8 writes, addr 0,8,…,56, `wrEnOut`=0xFF
  - filter: 5 writes, addr 16384..16416, last `wrEnOut`=0x0F
  - `startOut` once; after 4 `resValidIn`, `doneOut` pulses and `busyOut` falls.
- Same frames with `valid` toggled pseudo-randomly → identical write sequence (addr, data, enables).
- Data 3x3 (9 words) → 5th write at addr 32 with `wrEnOut`=0x0F and `wrDataOut[31:0]`=9.
- Filter 5x5 on 4x4 data → `errorOut`=1 after filter rows beat, readies low, no `startOut`; persists until `rst`.
- 4x4 header with `dataLastIn` on beat 15 → ERR, no further writes.
- `rst` asserted mid-DLOAD, then full 2x2/1x1 frame → writes restart at addr 0 and FILT_ADDR; 4 results → `doneOut`.
